// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: 0-cycle hit, 4-beat line refill over req/ack.
// Optional hit/miss statistics outputs are enabled by defining ICACHE_STATS_EN.
`timescale 1ns/1ps
module icache_responder #(
  parameter int          ADDR_W   = 16,
  parameter int          IDX_W    = 4,
  parameter int          OFF_W    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PC,
  input  logic              flush,
  output logic [31:0]       Instruction,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int NLINES = 1 << IDX_W;
  localparam int NWORDS = 1 << (IDX_W + OFF_W);

  typedef enum logic [1:0] {LOOKUP, REFILL, FILL_DONE} state_t;

  state_t             state_q, state_d;
  logic [NLINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]   miss_idx_q, miss_idx_d;
  logic [OFF_W-1:0]   cnt_q, cnt_d;
  logic               flush_pend_q, flush_pend_d;

  logic [TAG_W-1:0]   tag_q  [NLINES];
  logic [31:0]        data_q [NWORDS];

  logic [TAG_W-1:0]   pc_tag;
  logic [IDX_W-1:0]   pc_idx;
  logic [OFF_W-1:0]   pc_off;
  logic               hit;
  logic               beat_ack;
  logic               last_beat;

  assign pc_tag    = PC[ADDR_W-1:IDX_W+OFF_W];
  assign pc_idx    = PC[IDX_W+OFF_W-1:OFF_W];
  assign pc_off    = PC[OFF_W-1:0];
  assign hit       = (state_q == LOOKUP) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  // Acks outside REFILL are not tied to an outstanding request and are dropped.
  assign beat_ack  = (state_q == REFILL) && mem_ack;
  assign last_beat = beat_ack && (cnt_q == {OFF_W{1'b1}});

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    miss_tag_d   = miss_tag_q;
    miss_idx_d   = miss_idx_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    stall        = 1'b1;
    Instruction  = NOP_INST;
    mem_req      = 1'b0;
    mem_addr     = {miss_tag_q, miss_idx_q, cnt_q};

    // Lookup above reads valid_q, so a hit on the flush edge still returns data.
    if (flush) valid_d = '0;

    case (state_q)
      LOOKUP: begin
        if (hit) begin
          stall       = 1'b0;
          Instruction = data_q[{pc_idx, pc_off}];
        end else begin
          state_d    = REFILL;
          miss_tag_d = pc_tag;
          miss_idx_d = pc_idx;
          cnt_d      = '0;
        end
      end
      REFILL: begin
        mem_req = 1'b1;
        if (flush) flush_pend_d = 1'b1;
        if (beat_ack) cnt_d = cnt_q + OFF_W'(1);
        if (last_beat) begin
          state_d = FILL_DONE;
          // A flush seen at any point of the refill leaves the new line invalid.
          if (!(flush_pend_q || flush)) valid_d[miss_idx_q] = 1'b1;
        end
      end
      FILL_DONE: begin
        state_d      = LOOKUP;
        flush_pend_d = 1'b0;
      end
      default: state_d = LOOKUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOOKUP;
      valid_q      <= '0;
      miss_tag_q   <= '0;
      miss_idx_q   <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      miss_tag_q   <= miss_tag_d;
      miss_idx_q   <= miss_idx_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Storage arrays carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (beat_ack) data_q[{miss_idx_q, cnt_q}] <= mem_rdata;
    if (last_beat) tag_q[miss_idx_q] <= miss_tag_q;
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit) hit_cnt_q <= sat_inc(hit_cnt_q);
      if ((state_q == LOOKUP) && !hit) miss_cnt_q <= sat_inc(miss_cnt_q);
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Randomized scoreboard bench for icache_responder with a line-level cache model and a
// wait-state memory responder; statistics checks compile in when ICACHE_STATS_EN is defined.
`timescale 1ns/1ps
module tb_icache_responder;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, flush, mem_ack;
  logic [15:0] PC;
  logic [31:0] mem_rdata;
  logic [31:0] Instruction;
  logic        stall, mem_req;
  logic [15:0] mem_addr;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  icache_responder #(.ADDR_W(16), .IDX_W(4), .OFF_W(2), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .PC(PC), .flush(flush),
    .Instruction(Instruction), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];
  logic [15:0] addr_q[$];
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  logic [31:0] mon_exp;
  bit          mvalid[16];
  logic [9:0]  mtag[16];

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return 32'h1000_0000 + {16'h0000, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void clear_model();
    for (int i = 0; i < 16; i++) begin
      mvalid[i] = 1'b0;
      mtag[i]   = '0;
    end
  endfunction

  function automatic bit model_hit(input logic [15:0] pc);
    logic [3:0] ix;
    ix = pc[5:2];
    return mvalid[ix] && (mtag[ix] == pc[15:6]);
  endfunction

  // Instruction monitor: NOP while stalled, scoreboard head when data is presented.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (stall) check("nop_while_stall", Instruction, NOP);
      else if (sb_q.size() > 0) begin
        mon_exp = sb_q.pop_front();
        check("instr", Instruction, mon_exp);
      end
    end
  end

  // Memory responder: checks every requested address, acks after wait_cfg wait cycles,
  // and sprinkles stray acks while no request is outstanding.
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_req === 1'b1) begin
      if (addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req actual=%h required=none", mem_addr);
        mem_ack = 1'b0;
      end else begin
        check("mem_addr", {16'h0000, mem_addr}, {16'h0000, addr_q[0]});
        if (wait_cnt >= wait_cfg) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          wait_cnt  = 0;
          void'(addr_q.pop_front());
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end
    end else begin
      mem_ack   = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      wait_cnt  = 0;
    end
  end

  // Called at posedge+1. flush_beat>=0 pulses flush while that beat is on mem_addr;
  // flush_now asserts flush in the lookup cycle itself (used only on predicted hits).
  task automatic fetch(input logic [15:0] pc, input int flush_beat, input bit flush_now);
    logic [3:0] ix;
    bit         h;
    int         fills, exp_lat, n;
    bit         fl_done, fl_active;
    ix      = pc[5:2];
    h       = model_hit(pc);
    fills   = h ? 0 : ((flush_beat >= 0) ? 2 : 1);
    exp_lat = fills * (4 * (wait_cfg + 1) + 2);
    for (int f = 0; f < fills; f++)
      for (int b = 0; b < 4; b++) addr_q.push_back({pc[15:2], 2'(b)});
    sb_q.push_back(mem_word(pc));
    PC        = pc;
    flush     = flush_now;
    n         = 0;
    fl_done   = 1'b0;
    fl_active = 1'b0;
    forever begin
      @(negedge clk);
      if (stall === 1'b0) break;
      n++;
      if (fl_active) begin
        flush     = 1'b0;
        fl_active = 1'b0;
      end else if (flush_beat >= 0 && !fl_done && mem_req === 1'b1 &&
                   mem_addr[1:0] == 2'(flush_beat)) begin
        flush     = 1'b1;
        fl_done   = 1'b1;
        fl_active = 1'b1;
      end
      if (n > 120) begin
        checks++;
        errors++;
        $display("FAIL fetch_timeout pc=%h actual=%0d stall cycles required=%0d", pc, n, exp_lat);
        sb_q.delete();
        addr_q.delete();
        break;
      end
    end
    check("stall_cycles", n, exp_lat);
    if (!h) begin
      if (flush_beat >= 0) clear_model();
      mvalid[ix] = 1'b1;
      mtag[ix]   = pc[15:6];
    end
    if (flush_now) clear_model();
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic flush_op();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    clear_model();
  endtask

  initial begin
    logic [15:0] pc;
    bit          found;
    bit          last_flush;
    int          r;
`ifdef ICACHE_STATS_EN
    logic [15:0] miss_snap;
`endif
    rst = 1'b1; flush = 1'b0; PC = 16'h0000; mem_ack = 1'b0; mem_rdata = '0;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'h0, stall}, 32'h1);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_addr", {16'h0000, mem_addr}, 32'h0);
    check("rst_instr", Instruction, NOP);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Cold miss then same-line hits
    wait_cfg = 0;
    fetch(16'h0000, -1, 1'b0);
    fetch(16'h0001, -1, 1'b0);
    fetch(16'h0002, -1, 1'b0);
    fetch(16'h0003, -1, 1'b0);
`ifdef ICACHE_STATS_EN
    check("miss_count_cold", {16'h0, miss_count}, 32'd1);
    check("hit_count_cold", {16'h0, hit_count}, 32'd4);
`endif

    // Slow memory
    wait_cfg = 3;
    fetch(16'h0020, -1, 1'b0);
    fetch(16'h0023, -1, 1'b0);

    // Conflict on index 1
    wait_cfg = 0;
    fetch(16'h0004, -1, 1'b0);
    fetch(16'h0044, -1, 1'b0);
    fetch(16'h0004, -1, 1'b0);

    // Flush mid-refill, then earlier line lost too
    fetch(16'h0000, -1, 1'b0);
    fetch(16'h0010, 1, 1'b0);
    fetch(16'h0010, -1, 1'b0);
    fetch(16'h0000, -1, 1'b0);

    // Flush on the same edge as a hit
    fetch(16'h0011, -1, 1'b1);
    fetch(16'h0011, -1, 1'b0);

    // Reset during beat 1
    flush_op();
    for (int b = 0; b < 4; b++) addr_q.push_back(16'h0030 + 16'(b));
    PC    = 16'h0030;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_addr == 16'h0031) found = 1'b1;
    end
    check("reach_beat1", {31'h0, found}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_drops_req", {31'h0, mem_req}, 32'h0);
    addr_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    fetch(16'h0000, -1, 1'b0);
    fetch(16'h0030, -1, 1'b0);
    fetch(16'h0031, -1, 1'b0);

    // Randomized traffic
    last_flush = 1'b0;
    for (int i = 0; i < 150; i++) begin
      r        = $urandom_range(0, 9);
      wait_cfg = $urandom_range(0, 2);
      pc       = {10'($urandom_range(0, 2)), 4'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if (r == 0 && !last_flush) begin
        flush_op();
        last_flush = 1'b1;
      end else if (r == 1 && model_hit(pc)) begin
        fetch(pc, -1, 1'b1);
        last_flush = 1'b1;
      end else if (r == 2) begin
        fetch(pc, $urandom_range(0, 3), 1'b0);
        last_flush = 1'b0;
      end else begin
        fetch(pc, -1, 1'b0);
        last_flush = 1'b0;
      end
    end
    wait_cfg = 0;
    fetch(16'h0000, -1, 1'b0);

`ifdef ICACHE_STATS_EN
    miss_snap = miss_count;
    repeat (70000) @(posedge clk);
    #1;
    check("hit_count_sat", {16'h0, hit_count}, 32'h0000_FFFF);
    check("miss_count_hold", {16'h0, miss_count}, {16'h0, miss_snap});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
